// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, small word-addressed instruction memory, and a
// registered instruction output. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          stall,
  input  logic                          branch_en,
  input  logic [31:0]                   branch_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   instr,
  output logic [31:0]                   instr_pc,
  output logic                          instr_valid,
  output logic                          halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                   fetch_cnt,
  output logic [31:0]                   stall_cnt,
`endif
  output logic [1:0]                    dbg_state_o,
  output logic [31:0]                   dbg_pc_o
);

  localparam int          AW       = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

  typedef enum logic [1:0] {
    ST_BUBBLE = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        fetch_fire;
  logic        stall_hit;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] rd_word;
  logic [31:0] br_pc;
  logic [31:0] pc_inc;

  // Read sees the pre-edge contents, so a same-cycle write to the fetched word
  // delivers the old data.
  always_ff @(posedge CLK) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign rd_word = imem[pc_q[AW+1:2]];
  assign br_pc   = branch_target & 32'hFFFF_FFFC;
  assign pc_inc  = pc_q + 32'd4;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_BUBBLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Output contract: instr/instr_pc are meaningful only while instr_valid=1;
  // there is no ready, downstream back-pressure arrives as stall (hold).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fetch_fire = 1'b0;
    stall_hit  = 1'b0;
    case (state_q)
      ST_BUBBLE: begin
        instr_d = '0;
        valid_d = 1'b0;
        if (branch_en) begin
          pc_d    = br_pc;
          state_d = ST_BUBBLE;
        end else if (pc_q >= PC_LIMIT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (branch_en) begin
          pc_d    = br_pc;
          instr_d = '0;
          valid_d = 1'b0;
          state_d = ST_BUBBLE;
        end else if (stall) begin
          stall_hit = 1'b1;
        end else begin
          instr_d    = rd_word;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_inc;
          fetch_fire = 1'b1;
          if (pc_inc >= PC_LIMIT) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        instr_d = '0;
        valid_d = 1'b0;
        if (branch_en) begin
          pc_d    = br_pc;
          state_d = ST_BUBBLE;
        end
      end
      default: state_d = ST_BUBBLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_fire && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_hit && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign dbg_state_o = state_q;
  assign dbg_pc_o    = pc_q;

endmodule
